// File: rtl/mtx_seq_gen.sv
// Multi-channel symbol sequencer: emits NCH phase-accumulator words per sample,
// framed into symbols with gaps, start-phase stepping and continuous/one-shot/triggered modes.
module mtx_seq_gen #(
  parameter int PHASE_WIDTH = 24,
  parameter int NSIG_WIDTH  = 24,
  parameter int NSYMB_WIDTH = 16,
  parameter int GAP_WIDTH   = 16,
  parameter int REG_WIDTH   = 12,
  parameter int NCH         = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [1:0]                   cfg_mode,
  input  logic [NSIG_WIDTH-1:0]        cfg_nsig,
  input  logic [NSYMB_WIDTH-1:0]       cfg_nsymb,
  input  logic [GAP_WIDTH-1:0]         cfg_gap,
  input  logic [PHASE_WIDTH-1:0]       cfg_ph_inc,
  input  logic [PHASE_WIDTH-1:0]       cfg_ch_inc,
  input  logic [PHASE_WIDTH-1:0]       cfg_ph_step,
  output logic [NCH*PHASE_WIDTH-1:0]   ph,
  output logic [PHASE_WIDTH-1:0]       ph_start,
  output logic [NSIG_WIDTH-1:0]        sigN,
  output logic [NSYMB_WIDTH-1:0]       symbN,
  output logic                         tx_valid,
  output logic                         tx_trig,
  output logic                         done,
  input  logic [REG_WIDTH-1:0]         fp_gpio_in,
  output logic [REG_WIDTH-1:0]         fp_gpio_out,
  output logic [REG_WIDTH-1:0]         fp_gpio_ddr,
  output logic [2:0]                   state_dbg
);

  typedef enum logic [2:0] {IDLE, ARM, RUN, GAP, DONE} state_t;

  state_t state, next_state;

  logic [1:0]             mode_r;
  logic [NSIG_WIDTH-1:0]  nsig_r;
  logic [NSYMB_WIDTH-1:0] nsymb_r;
  logic [GAP_WIDTH-1:0]   gap_r;
  logic [GAP_WIDTH-1:0]   gap_cnt;
  logic [PHASE_WIDTH-1:0] step_r;
  logic [PHASE_WIDTH-1:0] inc_r [NCH];
  logic [PHASE_WIDTH-1:0] ph_r  [NCH];
  logic [2:0]             sync_r;
  logic                   eof_r;
  logic                   tog_r;
  logic                   unused_gpio;

  logic frame_start, sym_start, sample_adv, gap_enter, done_enter;
  logic last_sample, last_symb, trig_edge;

  assign last_sample = (sigN == nsig_r - NSIG_WIDTH'(1));
  assign last_symb   = (symbN == nsymb_r - NSYMB_WIDTH'(1));
  assign trig_edge   = sync_r[1] & ~sync_r[2];
  assign unused_gpio = ^fp_gpio_in;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state  = state;
    frame_start = 1'b0;
    sym_start   = 1'b0;
    sample_adv  = 1'b0;
    gap_enter   = 1'b0;
    done_enter  = 1'b0;
    if (!enable) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: if (cfg_mode != 2'd3) next_state = ARM;
        ARM: if (mode_r != 2'd2 || trig_edge) begin
          next_state  = RUN;
          frame_start = 1'b1;
        end
        RUN: begin
          if (!last_sample) begin
            sample_adv = 1'b1;
          end else if (last_symb && mode_r != 2'd0) begin
            next_state = DONE;
            done_enter = 1'b1;
          end else if (gap_r != '0) begin
            next_state = GAP;
            gap_enter  = 1'b1;
          end else if (last_symb) begin
            frame_start = 1'b1;
          end else begin
            sym_start = 1'b1;
          end
        end
        GAP: if (gap_cnt == GAP_WIDTH'(1)) begin
          next_state  = RUN;
          frame_start = eof_r;
          sym_start   = ~eof_r;
        end
        DONE: next_state = DONE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Trigger pin crosses in through two flops; the third holds the previous value for edge detect.
  always_ff @(posedge clk) begin
    if (!reset) sync_r <= '0;
    else        sync_r <= {sync_r[1:0], fp_gpio_in[4]};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_r  <= '0;
      nsig_r  <= '0;
      nsymb_r <= '0;
      gap_r   <= '0;
      step_r  <= '0;
      for (int c = 0; c < NCH; c++) inc_r[c] <= '0;
    end else if (state == IDLE && next_state == ARM) begin
      mode_r  <= cfg_mode;
      nsig_r  <= (cfg_nsig == '0) ? NSIG_WIDTH'(1) : cfg_nsig;
      nsymb_r <= (cfg_nsymb == '0) ? NSYMB_WIDTH'(1) : cfg_nsymb;
      gap_r   <= cfg_gap;
      step_r  <= cfg_ph_step;
      for (int c = 0; c < NCH; c++)
        inc_r[c] <= cfg_ph_inc + PHASE_WIDTH'(c) * cfg_ch_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || next_state == IDLE) begin
      for (int c = 0; c < NCH; c++) ph_r[c] <= '0;
      ph_start <= '0;
      sigN     <= '0;
      symbN    <= '0;
      tx_valid <= 1'b0;
      tx_trig  <= 1'b0;
      done     <= 1'b0;
      tog_r    <= 1'b0;
      gap_cnt  <= '0;
      eof_r    <= 1'b0;
    end else begin
      tx_trig <= frame_start;
      if (frame_start) begin
        for (int c = 0; c < NCH; c++) ph_r[c] <= '0;
        ph_start <= '0;
        sigN     <= '0;
        symbN    <= '0;
        tx_valid <= 1'b1;
        tog_r    <= ~tog_r;
        eof_r    <= 1'b0;
      end else if (sym_start) begin
        // every channel restarts from the new symbol's start phase
        for (int c = 0; c < NCH; c++) ph_r[c] <= ph_start + step_r;
        ph_start <= ph_start + step_r;
        sigN     <= '0;
        symbN    <= symbN + NSYMB_WIDTH'(1);
        tx_valid <= 1'b1;
        tog_r    <= ~tog_r;
      end else if (sample_adv) begin
        for (int c = 0; c < NCH; c++) ph_r[c] <= ph_r[c] + inc_r[c];
        sigN <= sigN + NSIG_WIDTH'(1);
      end else if (gap_enter) begin
        tx_valid <= 1'b0;
        gap_cnt  <= gap_r;
        eof_r    <= last_symb;
      end else if (done_enter) begin
        tx_valid <= 1'b0;
        done     <= 1'b1;
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt - GAP_WIDTH'(1);
      end
    end
  end

  always_comb begin
    ph = '0;
    for (int c = 0; c < NCH; c++) ph[c*PHASE_WIDTH +: PHASE_WIDTH] = ph_r[c];
  end

  assign fp_gpio_out = {{(REG_WIDTH-4){1'b0}}, done, tog_r, tx_valid, tx_trig};
  assign fp_gpio_ddr = REG_WIDTH'('h00F);
  assign state_dbg   = state;

endmodule

// File: tb/tb_mtx_seq_gen.sv
// Bench for mtx_seq_gen: each cycle's outputs are compared against a sample stream
// generated frame-by-frame from the symbol/sample arithmetic.
`timescale 1ns/1ps
module tb_mtx_seq_gen;
  localparam int PW  = 24;
  localparam int SW  = 24;
  localparam int YW  = 16;
  localparam int GW  = 16;
  localparam int RW  = 12;
  localparam int NCH = 4;
  localparam int W   = 3 + SW + YW + PW + NCH*PW + 2*RW;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [1:0]        cfg_mode;
  logic [SW-1:0]     cfg_nsig;
  logic [YW-1:0]     cfg_nsymb;
  logic [GW-1:0]     cfg_gap;
  logic [PW-1:0]     cfg_ph_inc;
  logic [PW-1:0]     cfg_ch_inc;
  logic [PW-1:0]     cfg_ph_step;
  logic [NCH*PW-1:0] ph;
  logic [PW-1:0]     ph_start;
  logic [SW-1:0]     sigN;
  logic [YW-1:0]     symbN;
  logic              tx_valid;
  logic              tx_trig;
  logic              done;
  logic [RW-1:0]     fp_gpio_in;
  logic [RW-1:0]     fp_gpio_out;
  logic [RW-1:0]     fp_gpio_ddr;
  logic [2:0]        state_dbg;

  mtx_seq_gen #(.PHASE_WIDTH(PW), .NSIG_WIDTH(SW), .NSYMB_WIDTH(YW),
                .GAP_WIDTH(GW), .REG_WIDTH(RW), .NCH(NCH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_mode(cfg_mode),
    .cfg_nsig(cfg_nsig), .cfg_nsymb(cfg_nsymb), .cfg_gap(cfg_gap),
    .cfg_ph_inc(cfg_ph_inc), .cfg_ch_inc(cfg_ch_inc), .cfg_ph_step(cfg_ph_step),
    .ph(ph), .ph_start(ph_start), .sigN(sigN), .symbN(symbN),
    .tx_valid(tx_valid), .tx_trig(tx_trig), .done(done),
    .fp_gpio_in(fp_gpio_in), .fp_gpio_out(fp_gpio_out), .fp_gpio_ddr(fp_gpio_ddr),
    .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // reference model: current expected output record and latched configuration
  logic          m_valid, m_trig, m_done, m_tog;
  logic [SW-1:0] m_sig;
  logic [YW-1:0] m_sym;
  logic [PW-1:0] m_phs;
  logic [PW-1:0] m_ph [NCH];
  int            c_mode, c_nsig, c_nsymb, c_gap;
  logic [PW-1:0] c_inc, c_chinc, c_step;

  function automatic logic [W-1:0] pack_exp();
    logic [NCH*PW-1:0] p;
    p = '0;
    for (int c = 0; c < NCH; c++) p[c*PW +: PW] = m_ph[c];
    return {m_valid, m_trig, m_done, m_sig, m_sym, m_phs, p,
            8'h00, m_done, m_tog, m_valid, m_trig, 12'h00F};
  endfunction

  function automatic logic [W-1:0] observed();
    return {tx_valid, tx_trig, done, sigN, symbN, ph_start, ph, fp_gpio_out, fp_gpio_ddr};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_idle();
    m_valid = 1'b0; m_trig = 1'b0; m_done = 1'b0; m_tog = 1'b0;
    m_sig = '0; m_sym = '0; m_phs = '0;
    for (int c = 0; c < NCH; c++) m_ph[c] = '0;
  endtask

  task automatic push_cur();
    exp_q.push_back(pack_exp());
  endtask

  // One frame: sample n of symbol k on channel c is k*step + n*(inc + c*chinc).
  task automatic push_frame();
    int ns, nk;
    ns = (c_nsig == 0) ? 1 : c_nsig;
    nk = (c_nsymb == 0) ? 1 : c_nsymb;
    for (int k = 0; k < nk; k++) begin
      m_tog = ~m_tog;
      for (int n = 0; n < ns; n++) begin
        m_valid = 1'b1;
        m_trig  = (k == 0 && n == 0);
        m_done  = 1'b0;
        m_sig   = SW'(n);
        m_sym   = YW'(k);
        m_phs   = PW'(k * c_step);
        for (int c = 0; c < NCH; c++)
          m_ph[c] = PW'(k * c_step + n * (c_inc + c * c_chinc));
        push_cur();
      end
      if (k < nk - 1 || c_mode == 0) begin
        for (int g = 0; g < c_gap; g++) begin
          m_valid = 1'b0;
          m_trig  = 1'b0;
          push_cur();
        end
      end
    end
    if (c_mode != 0) begin
      m_valid = 1'b0;
      m_trig  = 1'b0;
      m_done  = 1'b1;
      push_cur();
    end
  endtask

  // driver tasks
  task automatic tick(input string tag);
    logic [W-1:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s no expectation queued", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, observed(), e);
    end
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) tick(tag);
  endtask

  task automatic start_run(input int mode, input int nsig, input int nsymb, input int gap,
                           input logic [PW-1:0] inc, input logic [PW-1:0] chinc,
                           input logic [PW-1:0] step);
    cfg_mode = 2'(mode); cfg_nsig = SW'(nsig); cfg_nsymb = YW'(nsymb); cfg_gap = GW'(gap);
    cfg_ph_inc = inc; cfg_ch_inc = chinc; cfg_ph_step = step;
    c_mode = mode; c_nsig = nsig; c_nsymb = nsymb; c_gap = gap;
    c_inc = inc; c_chinc = chinc; c_step = step;
    enable = 1'b1;
    model_idle();
    push_cur(); tick("arm");
    if (mode == 2) begin
      push_cur(); tick("arm_wait");
      fp_gpio_in[4] = 1'b1;
      push_cur(); tick("trig_sync1");
      fp_gpio_in[4] = 1'b0;
      push_cur(); tick("trig_sync2");
    end
    // configuration now latched: later changes must not reach the frame
    cfg_mode    = 2'($urandom_range(0, 3));
    cfg_nsig    = SW'($urandom_range(0, 40));
    cfg_nsymb   = YW'($urandom_range(0, 9));
    cfg_gap     = GW'($urandom_range(0, 7));
    cfg_ph_inc  = PW'($urandom);
    cfg_ch_inc  = PW'($urandom);
    cfg_ph_step = PW'($urandom);
    push_frame();
  endtask

  task automatic end_run(input string tag);
    enable = 1'b0;
    exp_q.delete();
    model_idle();
    push_cur(); tick(tag);
    push_cur(); tick({tag, "_idle"});
    check({tag, "_state"}, W'(state_dbg), '0);
  endtask

  task automatic hold_done(input int n);
    for (int i = 0; i < n; i++) begin
      push_cur(); tick("done_hold");
    end
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; cfg_mode = '0; cfg_nsig = '0; cfg_nsymb = '0;
    cfg_gap = '0; cfg_ph_inc = '0; cfg_ch_inc = '0; cfg_ph_step = '0; fp_gpio_in = '0;
    c_mode = 0; c_nsig = 1; c_nsymb = 1; c_gap = 0; c_inc = '0; c_chinc = '0; c_step = '0;
    model_idle();

    push_cur(); tick("reset");
    push_cur(); tick("reset");
    check("reset_state", W'(state_dbg), '0);
    reset = 1'b1;
    push_cur(); tick("post_reset");

    // reserved mode never leaves IDLE
    cfg_mode = 2'd3; enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_cur(); tick("mode3");
    end
    check("mode3_state", W'(state_dbg), '0);
    enable = 1'b0;
    push_cur(); tick("mode3_off");

    // one-shot, contiguous symbols
    start_run(1, 8, 4, 0, 24'h000100, 24'h000100, 24'h400000);
    drain("oneshot_nogap");
    hold_done(3);
    end_run("oneshot_nogap_off");

    // one-shot with gaps
    start_run(1, 4, 3, 5, PW'($urandom), PW'($urandom), PW'($urandom));
    drain("oneshot_gap");
    hold_done(2);
    end_run("oneshot_gap_off");

    // continuous, wrapping increments
    start_run(0, 16, 2, 0, 24'hFFFFFF, 24'h123457, 24'h0ABCDE);
    push_frame();
    push_frame();
    drain("cont_wrap");
    end_run("cont_wrap_off");

    // continuous with gap between frames
    start_run(0, 3, 2, 3, PW'($urandom), PW'($urandom), PW'($urandom));
    push_frame();
    drain("cont_gap");
    end_run("cont_gap_off");

    // triggered one-shot, 1-sample symbols, retrigger ignored
    start_run(2, 0, 5, 1, PW'($urandom), PW'($urandom), PW'($urandom));
    tick("trig_run"); tick("trig_run");
    fp_gpio_in[4] = 1'b1;
    tick("trig_run_pulse");
    fp_gpio_in[4] = 1'b0;
    drain("trig_run");
    fp_gpio_in[4] = 1'b1;
    hold_done(1);
    fp_gpio_in[4] = 1'b0;
    hold_done(4);
    end_run("trig_off");

    // enable dropped at sample 5 of symbol 1
    start_run(1, 8, 3, 0, PW'($urandom), PW'($urandom), PW'($urandom));
    for (int i = 0; i < 14; i++) tick("abort_run");
    end_run("abort_enable");

    // reset mid-frame
    start_run(0, 6, 3, 2, PW'($urandom), PW'($urandom), PW'($urandom));
    for (int i = 0; i < 10; i++) tick("reset_run");
    reset = 1'b0; enable = 1'b0;
    exp_q.delete();
    model_idle();
    push_cur(); tick("reset_mid");
    check("reset_mid_state", W'(state_dbg), '0);
    reset = 1'b1;
    push_cur(); tick("reset_release");

    // randomized runs
    for (int r = 0; r < 10; r++) begin
      int md;
      md = int'($urandom_range(0, 2));
      start_run(md, int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 3)), PW'($urandom), PW'($urandom), PW'($urandom));
      if (md == 0) push_frame();
      drain("rand_run");
      if (md != 0) hold_done(1);
      end_run("rand_off");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mtx_seq_gen.md
# mtx_seq_gen

Parametrised multi-channel symbol sequencer for the ANC transmit path, the next generation of the single-channel multi-tone TX controller. Generates NCH phase-accumulator words per sample, framed into NSYMB symbols of NSIG samples with programmable inter-symbol gaps, per-symbol start-phase stepping and per-channel frequency offsets. Supports continuous, one-shot and GPIO-triggered modes. Phase words feed the downstream sin/cos LUT/CORDIC stage; GPIO outputs mirror framing for scope/sync.

## Interface
- PHASE_WIDTH, 24, phase accumulator width
- NSIG_WIDTH, 24, sample-counter width
- NSYMB_WIDTH, 16, symbol-counter width
- GAP_WIDTH, 16, inter-symbol gap counter width
- REG_WIDTH, 12, front-panel GPIO width (≥ 5)
- NCH, 4, number of phase channels (1..8)

- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- enable  in  1  level; low forces IDLE
- cfg_mode  in  2  0 continuous, 1 one-shot, 2 GPIO-triggered one-shot, 3 reserved (stay IDLE)
- cfg_nsig  in  NSIG_WIDTH  samples per symbol (0 treated as 1)
- cfg_nsymb  in  NSYMB_WIDTH  symbols per frame (0 treated as 1)
- cfg_gap  in  GAP_WIDTH  idle cycles between symbols
- cfg_ph_inc  in  PHASE_WIDTH  channel-0 per-sample phase increment
- cfg_ch_inc  in  PHASE_WIDTH  extra increment per channel index
- cfg_ph_step  in  PHASE_WIDTH  start-phase advance per symbol
- ph  out  NCH*PHASE_WIDTH  channel c at bits [c*PW +: PW]
- ph_start  out  PHASE_WIDTH  start phase of current symbol
- sigN  out  NSIG_WIDTH  sample index within symbol
- symbN  out  NSYMB_WIDTH  symbol index within frame
- tx_valid  out  1  ph valid this cycle
- tx_trig  out  1  1-cycle pulse on frame's first sample
- done  out  1  level, one-shot frame finished
- fp_gpio_in  in  REG_WIDTH  bit 4 = external trigger
- fp_gpio_out  out  REG_WIDTH  bit0 tx_trig, bit1 tx_valid, bit2 symbol toggle, bit3 done, others 0
- fp_gpio_ddr  out  REG_WIDTH  constant 'h00F

## Operation
- States: IDLE, ARM, RUN, GAP, DONE.
- IDLE: outputs zero. enable=1 and mode≠3 → ARM; cfg_* latched into shadow registers on this transition; later cfg changes ignored until next IDLE.
- ARM: modes 0/1 → RUN next cycle; mode 2 waits for rising edge of fp_gpio_in[4] (2-flop synchronised, edge detected on synchronised value) → RUN.
- Frame start (ARM→RUN): symbN=0, sigN=0, ph_start=0, ph[c]=c*cfg_ch_offset-free, i.e. ph[c]=0; inc[c]=cfg_ph_inc + c*cfg_ch_inc (mod 2^PW, c constant per channel).
- RUN: tx_valid=1; each cycle ph[c]+=inc[c], sigN++. At sigN=nsig-1: if symbN=nsymb-1 → end of frame; else → GAP (cfg_gap>0) or directly next symbol.
- Next symbol: symbN++, ph_start+=cfg_ph_step, all ph[c]=new ph_start, sigN=0.
- GAP: tx_valid=0, ph held, counts cfg_gap cycles, then next symbol in RUN.
- End of frame: mode 0 → gap (if any) then frame restart (symbN=0, ph_start=0, tx_trig again); modes 1/2 → DONE.
- DONE: done=1, tx_valid=0; stays until enable=0 → IDLE.
- fp_gpio_out[2] toggles at every symbol start including symbol 0.
- All phase arithmetic modulo 2^PHASE_WIDTH; counters never exceed latched limits.

## Timing
- Reset (reset=0 at clk edge): state IDLE; ph, ph_start, sigN, symbN, tx_valid, tx_trig, done, fp_gpio_out = 0; fp_gpio_ddr='h00F always. Reset mid-frame aborts in one cycle.
- enable=0 in any state: IDLE on next edge, outputs zero next cycle.
- enable rising → first tx_valid 2 cycles later (modes 0/1); mode 2: 3 cycles after trigger edge on pin (2 sync + 1).
- Outputs registered; tx_trig coincides with first tx_valid of each frame, sigN=0, symbN=0.
- Frame length (mode 1) = nsymb*nsig valid cycles + (nsymb-1)*gap idle cycles; done asserts cycle after last valid sample.
- Triggers in ARM only; triggers in RUN/GAP/DONE ignored.

## Test plan
- Mode 1, NCH=4, nsig=8, nsymb=4, gap=0, ph_inc='h000100, ch_inc='h000100, ph_step='h400000 → 32 contiguous valid cycles; sample n of symbol k: ph[c]=k*'h400000+n*(c+1)*'h100; one tx_trig; done after cycle 32.
- Mode 1, nsig=4, nsymb=3, gap=5 → valid pattern 4 on/5 off/4 on/5 off/4 on; ph held during gaps; gpio bit2 toggles 3 times.
- Mode 0, nsig=16, nsymb=2, gap=0 → tx_trig every 32 cycles, ph_start wraps to 0 each frame; 'hFFFFFF increments wrap modulo 2^24.
- Mode 2: pulse fp_gpio_in[4] 1 cycle → tx_valid starts 3 cycles later; second pulse mid-frame ignored; cfg_nsig=0 gives 1-sample symbols.
- enable dropped at sample 5 of symbol 1, then reset=0 mid-frame in a re-run → outputs zero next cycle, IDLE; cfg change during RUN has no effect.
- mode=3 with enable=1 → remains IDLE, all outputs 0.
